// File: rtl/el2_omega_rev.sv
// Backward walker over the EL2 graph family: loads a row's sink column, then
// steps toward column 0 through chosen (or default) predecessors.
module el2_omega_rev #(
    parameter int ROWMSB = 1,
    parameter int COLMSB = ROWMSB + 2,
    parameter int DIGMSB = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pause,
    input  logic              restart,
    input  logic [ROWMSB:0]   rchoice,
    input  logic [COLMSB:0]   cchoice,
    input  logic [DIGMSB:0]   dchoice,
    output logic              colmsb,
    output logic              collsb,
    output logic              done
);

    localparam int unsigned COLBITS = COLMSB + 1;
    localparam logic [COLBITS-1:0] HALF = COLBITS'(1) << COLMSB;

    typedef enum logic [1:0] {LOAD, WALK, DONE} state_e;

    state_e              state_q, state_d;
    logic [ROWMSB:0]     row_q, row_d;
    logic [COLMSB:0]     col_q, col_d;
    logic [DIGMSB:0]     digit_q, digit_d;
    logic [COLMSB:0]     sink;
    logic                cvalid;
    logic                unused_state;

    function automatic logic is_digit(input logic [COLMSB:0] c);
        return (c > HALF) && c[0];
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
            row_q   <= '0;
            col_q   <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        digit_d = digit_q;
        sink    = '1 - (COLBITS'(rchoice) << 1);
        // Above the midpoint a predecessor must stay in the upper half.
        if (col_q <= HALF) cvalid = cchoice < col_q;
        else               cvalid = (cchoice >= HALF) && (cchoice < col_q);
        case (state_q)
            LOAD: begin
                row_d   = rchoice;
                col_d   = sink;
                digit_d = dchoice;
                state_d = WALK;
            end
            WALK: begin
                if (!(is_digit(col_q) && pause)) begin
                    if (col_q == '0) begin
                        state_d = DONE;
                    end else begin
                        col_d   = cvalid ? cchoice : col_q - COLBITS'(1);
                        digit_d = is_digit(col_d) ? dchoice : '0;
                    end
                end
            end
            DONE: begin
                if (restart) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        colmsb = col_q[COLMSB];
        collsb = col_q[0];
        done   = (state_q == DONE);
    end

    // Row and digit are walk state with no output decode; fold them so they count as read.
    assign unused_state = ^{row_q, digit_q};

endmodule

// File: tb/tb_el2_omega_rev.sv
// Directed bench for el2_omega_rev at default parameters (4-bit col, 2-bit row/digit).
module tb_el2_omega_rev;

    logic       clock;
    logic       reset_n;
    logic       pause;
    logic       restart;
    logic [1:0] rchoice;
    logic [3:0] cchoice;
    logic [1:0] dchoice;
    logic       colmsb;
    logic       collsb;
    logic       done;

    int unsigned tests_run;
    int unsigned tests_failed;

    el2_omega_rev #(.ROWMSB(1), .COLMSB(3), .DIGMSB(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .pause   (pause),
        .restart (restart),
        .rchoice (rchoice),
        .cchoice (cchoice),
        .dchoice (dchoice),
        .colmsb  (colmsb),
        .collsb  (collsb),
        .done    (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_col(input string tag, input logic [3:0] c, input logic [1:0] d, input logic dn);
        check({tag, ".col"},    32'(dut.col_q),   32'(c));
        check({tag, ".digit"},  32'(dut.digit_q), 32'(d));
        check({tag, ".done"},   32'(done),        32'(dn));
        check({tag, ".colmsb"}, 32'(colmsb),      32'(c[3]));
        check({tag, ".collsb"}, 32'(collsb),      32'(c[0]));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        pause   = 1'b0;
        restart = 1'b0;
        rchoice = 2'd0;
        cchoice = 4'd0;
        dchoice = 2'd0;

        #12;
        check_col("reset", 4'd0, 2'd0, 1'b0);
        check("reset.row", 32'(dut.row_q), 32'd0);

        reset_n = 1'b1;
        rchoice = 2'd2;
        dchoice = 2'd3;
        tick();
        check_col("load_r2", 4'd11, 2'd3, 1'b0);
        check("load_r2.row", 32'(dut.row_q), 32'd2);

        cchoice = 4'd8;
        tick();
        check_col("r2_to8", 4'd8, 2'd0, 1'b0);
        cchoice = 4'd0;
        tick();
        check_col("r2_to0", 4'd0, 2'd0, 1'b0);
        tick();
        check_col("r2_done", 4'd0, 2'd0, 1'b1);

        rchoice = 2'd0;
        dchoice = 2'd1;
        restart = 1'b1;
        tick();
        check("restart1.done", 32'(done), 32'd0);
        restart = 1'b0;
        tick();
        check_col("load_r0", 4'd15, 2'd1, 1'b0);
        check("load_r0.row", 32'(dut.row_q), 32'd0);

        pause   = 1'b1;
        restart = 1'b1;
        cchoice = 4'd3;
        dchoice = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_col("pause15", 4'd15, 2'd1, 1'b0);
        end
        restart = 1'b0;

        pause = 1'b0;
        tick();
        check_col("invalid3", 4'd14, 2'd0, 1'b0);

        pause   = 1'b1;
        cchoice = 4'd14;
        dchoice = 2'd1;
        tick();
        check_col("equal14", 4'd13, 2'd1, 1'b0);
        pause = 1'b0;

        cchoice = 4'd12;
        tick();
        check_col("to12", 4'd12, 2'd0, 1'b0);
        cchoice = 4'd9;
        dchoice = 2'd2;
        tick();
        check_col("digit9", 4'd9, 2'd2, 1'b0);
        cchoice = 4'd8;
        tick();
        check_col("to8", 4'd8, 2'd0, 1'b0);
        cchoice = 4'd2;
        tick();
        check_col("jump2", 4'd2, 2'd0, 1'b0);
        cchoice = 4'd5;
        tick();
        check_col("invalid5", 4'd1, 2'd0, 1'b0);
        cchoice = 4'd0;
        tick();
        check_col("to0", 4'd0, 2'd0, 1'b0);
        tick();
        check_col("done", 4'd0, 2'd0, 1'b1);

        rchoice = 2'd3;
        dchoice = 2'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_col("done_hold", 4'd0, 2'd0, 1'b1);
            check("done_hold.row", 32'(dut.row_q), 32'd0);
        end
        restart = 1'b1;
        tick();
        check_col("restart_load", 4'd0, 2'd0, 1'b0);
        restart = 1'b0;
        tick();
        check_col("reload_r3", 4'd9, 2'd0, 1'b0);
        check("reload_r3.row", 32'(dut.row_q), 32'd3);

        #2 reset_n = 1'b0;
        #1;
        check_col("reset_at9", 4'd0, 2'd0, 1'b0);
        check("reset_at9.row", 32'(dut.row_q), 32'd0);
        reset_n = 1'b1;
        rchoice = 2'd1;
        dchoice = 2'd2;
        tick();
        check_col("load_r1", 4'd13, 2'd2, 1'b0);

        #2 reset_n = 1'b0;
        #1;
        check_col("reset_at13", 4'd0, 2'd0, 1'b0);
        reset_n = 1'b1;
        tick();
        check_col("reload_r1", 4'd13, 2'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
